// File: rtl/triangle_assembler_if.sv
// Vertex-FIFO consumer side and triangle-output handshake bundle for triangle_assembler.
interface triangle_assembler_if #(
    parameter int unsigned VERT_W = 104
);
    localparam int unsigned AREA_W  = 35;
    localparam int unsigned COORD_W = 16;

    logic [VERT_W-1:0]        i_fifo_data;
    logic                     i_fifo_empty;
    logic                     o_fifo_re;
    logic                     o_tri_valid;
    logic                     i_tri_ready;
    logic [VERT_W-1:0]        o_v0;
    logic [VERT_W-1:0]        o_v1;
    logic [VERT_W-1:0]        o_v2;
    logic signed [AREA_W-1:0] o_area;
    logic [COORD_W-1:0]       o_bb_min_x;
    logic [COORD_W-1:0]       o_bb_max_x;
    logic [COORD_W-1:0]       o_bb_min_y;
    logic [COORD_W-1:0]       o_bb_max_y;
    logic [COORD_W-1:0]       o_drop_count;

    modport master (
        input  i_fifo_data, i_fifo_empty, i_tri_ready,
        output o_fifo_re, o_tri_valid, o_v0, o_v1, o_v2, o_area,
               o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y, o_drop_count
    );

    modport slave (
        output i_fifo_data, i_fifo_empty, i_tri_ready,
        input  o_fifo_re, o_tri_valid, o_v0, o_v1, o_v2, o_area,
               o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y, o_drop_count
    );
endinterface

// File: rtl/triangle_assembler.sv
// Groups FIFO vertices into triangles, computes doubled area and a clamped bounding box,
// drops degenerate/off-screen ones. Define BACKFACE_CULL_EN to also drop negative-area triangles.
module triangle_assembler #(
    parameter int unsigned VERT_W   = 104,
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    triangle_assembler_if.master bus
);
    localparam int unsigned COORD_W = 16;
    localparam int unsigned DIFF_W  = 17;
    localparam int unsigned PROD_W  = 34;
    localparam int unsigned AREA_W  = 35;
    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_AREA    = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [1:0]               idx;
    logic [VERT_W-1:0]        slot0, slot1, slot2;
    logic signed [AREA_W-1:0] area_q;
    logic signed [COORD_W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;

    logic                      pop_c;
    logic signed [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
    logic signed [DIFF_W-1:0]  dx1, dy1, dx2, dy2;
    logic signed [PROD_W-1:0]  prod_a, prod_b;
    logic signed [AREA_W-1:0]  area_c;
    logic signed [COORD_W-1:0] min_x_c, max_x_c, min_y_c, max_y_c;
    logic                      offscreen_c, cull_c, drop_c;

    function automatic logic signed [COORD_W-1:0] vert_x(input logic [VERT_W-1:0] v);
        return $signed(v[VERT_W-1 -: COORD_W]);
    endfunction

    function automatic logic signed [COORD_W-1:0] vert_y(input logic [VERT_W-1:0] v);
        return $signed(v[VERT_W-1-COORD_W -: COORD_W]);
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input logic signed [COORD_W-1:0] v,
                                                 input logic signed [COORD_W-1:0] lim);
        if (v[COORD_W-1])  return '0;
        else if (v > lim)  return lim;
        else               return v;
    endfunction

    // Pops are only allowed while collecting and never during reset.
    assign pop_c         = (state == S_COLLECT) && !bus.i_fifo_empty && !i_rst;
    assign bus.o_fifo_re = pop_c;

    always_comb begin
        x0 = vert_x(slot0);
        y0 = vert_y(slot0);
        x1 = vert_x(slot1);
        y1 = vert_y(slot1);
        x2 = vert_x(slot2);
        y2 = vert_y(slot2);
        dx1 = DIFF_W'(x1) - DIFF_W'(x0);
        dy1 = DIFF_W'(y1) - DIFF_W'(y0);
        dx2 = DIFF_W'(x2) - DIFF_W'(x0);
        dy2 = DIFF_W'(y2) - DIFF_W'(y0);
        prod_a = PROD_W'(dx1) * PROD_W'(dy2);
        prod_b = PROD_W'(dx2) * PROD_W'(dy1);
        area_c = AREA_W'(prod_a) - AREA_W'(prod_b);
        min_x_c = x0;
        max_x_c = x0;
        min_y_c = y0;
        max_y_c = y0;
        if (x1 < min_x_c) min_x_c = x1;
        if (x2 < min_x_c) min_x_c = x2;
        if (x1 > max_x_c) max_x_c = x1;
        if (x2 > max_x_c) max_x_c = x2;
        if (y1 < min_y_c) min_y_c = y1;
        if (y2 < min_y_c) min_y_c = y2;
        if (y1 > max_y_c) max_y_c = y1;
        if (y2 > max_y_c) max_y_c = y2;
    end

`ifdef BACKFACE_CULL_EN
    assign cull_c = area_q[AREA_W-1];
`else
    assign cull_c = 1'b0;
`endif

    assign offscreen_c = max_x_q[COORD_W-1] || (min_x_q > X_LIM) ||
                         max_y_q[COORD_W-1] || (min_y_q > Y_LIM);
    assign drop_c      = (area_q == '0) || offscreen_c || cull_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (pop_c && (idx == 2'd2)) state_nxt = S_AREA;
            S_AREA:    state_nxt = S_CHECK;
            S_CHECK:   state_nxt = drop_c ? S_COLLECT : S_OUT;
            S_OUT:     if (bus.i_tri_ready) state_nxt = S_COLLECT;
            default:   state_nxt = S_COLLECT;
        endcase
    end

    // Vertex slots, geometry registers and the held output triangle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx              <= '0;
            slot0            <= '0;
            slot1            <= '0;
            slot2            <= '0;
            area_q           <= '0;
            min_x_q          <= '0;
            max_x_q          <= '0;
            min_y_q          <= '0;
            max_y_q          <= '0;
            bus.o_tri_valid  <= 1'b0;
            bus.o_v0         <= '0;
            bus.o_v1         <= '0;
            bus.o_v2         <= '0;
            bus.o_area       <= '0;
            bus.o_bb_min_x   <= '0;
            bus.o_bb_max_x   <= '0;
            bus.o_bb_min_y   <= '0;
            bus.o_bb_max_y   <= '0;
            bus.o_drop_count <= '0;
        end else begin
            if (pop_c) begin
                case (idx)
                    2'd0:    slot0 <= bus.i_fifo_data;
                    2'd1:    slot1 <= bus.i_fifo_data;
                    default: slot2 <= bus.i_fifo_data;
                endcase
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
            if (state == S_AREA) begin
                area_q  <= area_c;
                min_x_q <= min_x_c;
                max_x_q <= max_x_c;
                min_y_q <= min_y_c;
                max_y_q <= max_y_c;
            end
            if (state == S_CHECK) begin
                if (drop_c) begin
                    if (bus.o_drop_count != '1) bus.o_drop_count <= bus.o_drop_count + 16'd1;
                end else begin
                    bus.o_tri_valid <= 1'b1;
                    bus.o_v0        <= slot0;
                    bus.o_v1        <= slot1;
                    bus.o_v2        <= slot2;
                    bus.o_area      <= area_q;
                    bus.o_bb_min_x  <= clamp(min_x_q, X_LIM);
                    bus.o_bb_max_x  <= clamp(max_x_q, X_LIM);
                    bus.o_bb_min_y  <= clamp(min_y_q, Y_LIM);
                    bus.o_bb_max_y  <= clamp(max_y_q, Y_LIM);
                end
            end
            if ((state == S_OUT) && bus.i_tri_ready) bus.o_tri_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: directed vector table, latency/backpressure/stall/reset
// sequences, and a randomized run scored against a behavioural geometry model.
`timescale 1ns/1ps
module tb_triangle_assembler;
    localparam int unsigned VERT_W = 104;
    localparam int SW     = 320;
    localparam int SH     = 240;
    localparam int FIFO_D = 4096;
    localparam int NVEC   = 10;
    localparam int NRAND  = 120;

    typedef struct {
        logic [VERT_W-1:0]  v0, v1, v2;
        logic signed [34:0] area;
        logic [15:0]        min_x, max_x, min_y, max_y;
    } tri_t;

    typedef struct {
        int     x0, y0, x1, y1, x2, y2;
        bit     emit;
        longint area;
        int     min_x, max_x, min_y, max_y;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    triangle_assembler_if #(.VERT_W(VERT_W)) bus ();

    triangle_assembler #(.VERT_W(VERT_W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Fall-through FIFO model: head is visible combinationally, popped on o_fifo_re.
    logic [VERT_W-1:0] fifo_mem [FIFO_D];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit stall  = 1'b0;

    assign bus.i_fifo_data  = fifo_mem[rd_ptr % FIFO_D];
    assign bus.i_fifo_empty = (rd_ptr == wr_ptr) || stall;

    always @(posedge i_clk) if (bus.o_fifo_re) rd_ptr <= rd_ptr + 1;

    task automatic push(input logic [VERT_W-1:0] v);
        fifo_mem[wr_ptr % FIFO_D] = v;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_v(input string nm, input logic [VERT_W-1:0] act, input logic [VERT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_tri(input string nm, input tri_t g, input tri_t e);
        chk_v({nm, ".v0"}, g.v0, e.v0);
        chk_v({nm, ".v1"}, g.v1, e.v1);
        chk_v({nm, ".v2"}, g.v2, e.v2);
        chk({nm, ".area"}, longint'(g.area), longint'(e.area));
        chk({nm, ".min_x"}, longint'(g.min_x), longint'(e.min_x));
        chk({nm, ".max_x"}, longint'(g.max_x), longint'(e.max_x));
        chk({nm, ".min_y"}, longint'(g.min_y), longint'(e.min_y));
        chk({nm, ".max_y"}, longint'(g.max_y), longint'(e.max_y));
    endtask

    function automatic logic [VERT_W-1:0] mkv(input int x, input int y, input int tag);
        return {16'(x), 16'(y), 8'(tag), 32'(tag * 7919 + 1), 32'(~tag)};
    endfunction

    function automatic int vx(input logic [VERT_W-1:0] v);
        return int'($signed(v[103:88]));
    endfunction

    function automatic int vy(input logic [VERT_W-1:0] v);
        return int'($signed(v[87:72]));
    endfunction

    function automatic int min3(input int p, input int q, input int r);
        return (p < q) ? ((p < r) ? p : r) : ((q < r) ? q : r);
    endfunction

    function automatic int max3(input int p, input int q, input int r);
        return (p > q) ? ((p > r) ? p : r) : ((q > r) ? q : r);
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Reference: cross product of edge vectors, screen rejection and clamping in plain integers.
    function automatic tri_t model(input logic [VERT_W-1:0] a, input logic [VERT_W-1:0] b,
                                   input logic [VERT_W-1:0] c, output bit emit);
        tri_t   t;
        longint ar;
        int     mnx, mxx, mny, mxy;
        ar  = longint'(vx(b) - vx(a)) * longint'(vy(c) - vy(a))
            - longint'(vx(c) - vx(a)) * longint'(vy(b) - vy(a));
        mnx = min3(vx(a), vx(b), vx(c));
        mxx = max3(vx(a), vx(b), vx(c));
        mny = min3(vy(a), vy(b), vy(c));
        mxy = max3(vy(a), vy(b), vy(c));
        emit = (ar != 0) && (mxx >= 0) && (mnx <= SW - 1) && (mxy >= 0) && (mny <= SH - 1);
`ifdef BACKFACE_CULL_EN
        if (ar < 0) emit = 1'b0;
`endif
        t.v0    = a;
        t.v1    = b;
        t.v2    = c;
        t.area  = 35'(ar);
        t.min_x = 16'(clampi(mnx, SW - 1));
        t.max_x = 16'(clampi(mxx, SW - 1));
        t.min_y = 16'(clampi(mny, SH - 1));
        t.max_y = 16'(clampi(mxy, SH - 1));
        return t;
    endfunction

    function automatic tri_t vec_exp(input vec_t v, input int tag);
        tri_t t;
        t.v0    = mkv(v.x0, v.y0, tag);
        t.v1    = mkv(v.x1, v.y1, tag + 1);
        t.v2    = mkv(v.x2, v.y2, tag + 2);
        t.area  = 35'(v.area);
        t.min_x = 16'(v.min_x);
        t.max_x = 16'(v.max_x);
        t.min_y = 16'(v.min_y);
        t.max_y = 16'(v.max_y);
        return t;
    endfunction

    function automatic int rcoord(input int lo, input int span);
        if ($urandom_range(9, 0) == 0) return int'($signed(16'($urandom)));
        return lo + int'($urandom_range(32'(span), 32'd0));
    endfunction

    // Output monitor: records handshakes, checks hold stability and that no pop overlaps valid.
    tri_t got_q[$];
    tri_t mon_cur, mon_last;
    bit   mon_hold = 1'b0;

    always @(negedge i_clk) begin
        if (i_rst || !bus.o_tri_valid) begin
            mon_hold = 1'b0;
        end else begin
            mon_cur.v0    = bus.o_v0;
            mon_cur.v1    = bus.o_v1;
            mon_cur.v2    = bus.o_v2;
            mon_cur.area  = bus.o_area;
            mon_cur.min_x = bus.o_bb_min_x;
            mon_cur.max_x = bus.o_bb_max_x;
            mon_cur.min_y = bus.o_bb_min_y;
            mon_cur.max_y = bus.o_bb_max_y;
            if (mon_hold) chk_tri("hold_stable", mon_cur, mon_last);
            chk("no_pop_while_valid", longint'(bus.o_fifo_re), 0);
            if (bus.i_tri_ready) begin
                got_q.push_back(mon_cur);
                mon_hold = 1'b0;
            end else begin
                mon_last = mon_cur;
                mon_hold = 1'b1;
            end
        end
    end

    task automatic wait_result(input int base_got, input int base_drop, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if ((got_q.size() > base_got) || (int'(bus.o_drop_count) != base_drop)) break;
        end
        repeat (2) tick();
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (got_q.size() >= n) break;
            tick();
        end
        tick();
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_valid"}, longint'(bus.o_tri_valid), 0);
        chk({nm, "_fifo_re"}, longint'(bus.o_fifo_re), 0);
        chk({nm, "_drop_count"}, longint'(bus.o_drop_count), 0);
        chk({nm, "_area"}, longint'(bus.o_area), 0);
        chk_v({nm, "_v0"}, bus.o_v0, '0);
        chk_v({nm, "_v2"}, bus.o_v2, '0);
        chk({nm, "_bb_max_x"}, longint'(bus.o_bb_max_x), 0);
        chk({nm, "_bb_max_y"}, longint'(bus.o_bb_max_y), 0);
    endtask

    vec_t tv [NVEC];

    initial begin
        tri_t              e;
        tri_t              exp_q[$];
        bit                emit;
        int                base_got, base_drop, exp_drops, k;
        int                ax, ay, bx, by, cx, cy;
        logic [VERT_W-1:0] a, b, c, d, f, g;

        tv[0] = '{10, 10, 20, 10, 10, 20, 1'b1, 100, 10, 20, 10, 20};
`ifdef BACKFACE_CULL_EN
        tv[1] = '{10, 10, 10, 20, 20, 10, 1'b0, 0, 0, 0, 0, 0};
`else
        tv[1] = '{10, 10, 10, 20, 20, 10, 1'b1, -100, 10, 20, 10, 20};
`endif
        tv[2] = '{0, 0, 5, 5, 10, 10, 1'b0, 0, 0, 0, 0, 0};
        tv[3] = '{-50, -50, -40, -50, -50, -40, 1'b0, 0, 0, 0, 0, 0};
        tv[4] = '{-5, -5, 400, 0, 0, 300, 1'b1, 123500, 0, 319, 0, 239};
        tv[5] = '{320, 0, 330, 0, 320, 10, 1'b0, 0, 0, 0, 0, 0};
        tv[6] = '{319, 239, 330, 239, 319, 250, 1'b1, 121, 319, 319, 239, 239};
        tv[7] = '{-32768, -32768, 32767, -32768, -32768, 32767, 1'b1,
                  longint'(65535) * 65535, 0, 319, 0, 239};
        tv[8] = '{0, -10, 10, -10, 0, -1, 1'b0, 0, 0, 0, 0, 0};
        tv[9] = '{0, 240, 10, 240, 0, 250, 1'b0, 0, 0, 0, 0, 0};

        bus.i_tri_ready = 1'b0;
        repeat (3) tick();
        chk_reset_state("reset");
        i_rst     = 1'b0;
        exp_drops = 0;

        // Directed vector table.
        bus.i_tri_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            base_got  = got_q.size();
            base_drop = int'(bus.o_drop_count);
            push(mkv(tv[i].x0, tv[i].y0, 3 * i));
            push(mkv(tv[i].x1, tv[i].y1, 3 * i + 1));
            push(mkv(tv[i].x2, tv[i].y2, 3 * i + 2));
            wait_result(base_got, base_drop, 40);
            chk($sformatf("vec%0d_emitted", i), got_q.size() - base_got, tv[i].emit ? 1 : 0);
            if (tv[i].emit && (got_q.size() > base_got))
                chk_tri($sformatf("vec%0d", i), got_q[base_got], vec_exp(tv[i], 3 * i));
            if (!tv[i].emit) exp_drops++;
            chk($sformatf("vec%0d_drop_count", i), longint'(bus.o_drop_count), exp_drops);
        end

        // Latency from a full FIFO and back-to-back throughput.
        base_got = got_q.size();
        a = mkv(10, 10, 100);
        b = mkv(20, 10, 101);
        c = mkv(10, 20, 102);
        d = mkv(30, 30, 103);
        f = mkv(50, 30, 104);
        g = mkv(30, 60, 105);
        push(a); push(b); push(c); push(d); push(f); push(g);
        k = 0;
        while ((k < 20) && !bus.o_tri_valid) begin
            tick();
            k++;
        end
        chk("latency_first_valid", k, 5);
        k = 0;
        do begin
            tick();
            k++;
        end while ((k < 20) && !bus.o_tri_valid);
        chk("throughput_next_valid", k, 6);
        wait_got(base_got + 2, 20);
        chk("throughput_count", got_q.size() - base_got, 2);
        if (got_q.size() >= base_got + 2) begin
            chk_tri("thru_a", got_q[base_got], model(a, b, c, emit));
            chk_tri("thru_b", got_q[base_got + 1], model(d, f, g, emit));
        end

        // Backpressure: hold ready low with the next triangle already queued.
        bus.i_tri_ready = 1'b0;
        base_got = got_q.size();
        a = mkv(100, 100, 200);
        b = mkv(150, 100, 201);
        c = mkv(100, 180, 202);
        d = mkv(5, 5, 203);
        f = mkv(60, 5, 204);
        g = mkv(5, 90, 205);
        push(a); push(b); push(c); push(d); push(f); push(g);
        k = 0;
        while ((k < 30) && !bus.o_tri_valid) begin
            tick();
            k++;
        end
        chk("bp_valid_seen", longint'(bus.o_tri_valid), 1);
        repeat (5) tick();
        chk("bp_fifo_held", wr_ptr - rd_ptr, 3);
        chk("bp_no_handshake", got_q.size() - base_got, 0);
        bus.i_tri_ready = 1'b1;
        wait_got(base_got + 2, 40);
        chk("bp_count", got_q.size() - base_got, 2);
        if (got_q.size() >= base_got + 2) begin
            chk_tri("bp_a", got_q[base_got], model(a, b, c, emit));
            chk_tri("bp_b", got_q[base_got + 1], model(d, f, g, emit));
        end

        // FIFO runs dry after two vertices; the third completes the same triangle.
        base_got = got_q.size();
        a = mkv(40, 40, 250);
        b = mkv(40, 90, 251);
        c = mkv(-20, 40, 252);
        push(a); push(b);
        repeat (10) tick();
        chk("stall_no_valid", longint'(bus.o_tri_valid), 0);
        chk("stall_popped_two", wr_ptr - rd_ptr, 0);
        push(c);
        wait_got(base_got + 1, 30);
        chk("stall_count", got_q.size() - base_got, 1);
        if (got_q.size() > base_got) chk_tri("stall_tri", got_q[base_got], model(a, b, c, emit));
        chk("stall_drop_count", longint'(bus.o_drop_count), exp_drops);

        // Reset after two pops: partial slots discarded, no pops while reset is high.
        push(mkv(7, 7, 300));
        push(mkv(9, 9, 301));
        repeat (3) tick();
        chk("prereset_popped", wr_ptr - rd_ptr, 0);
        i_rst = 1'b1;
        a = mkv(60, 60, 310);
        b = mkv(90, 60, 311);
        c = mkv(60, 100, 312);
        push(a); push(b); push(c);
        repeat (3) tick();
        chk_reset_state("midreset");
        chk("midreset_no_pop", wr_ptr - rd_ptr, 3);
        i_rst     = 1'b0;
        exp_drops = 0;
        base_got  = got_q.size();
        wait_got(base_got + 1, 30);
        chk("postreset_count", got_q.size() - base_got, 1);
        if (got_q.size() > base_got) chk_tri("postreset_tri", got_q[base_got], model(a, b, c, emit));
        chk("postreset_drop_count", longint'(bus.o_drop_count), 0);

        // Randomized triangles with random backpressure and FIFO stalls.
        base_got = got_q.size();
        for (int t = 0; t < NRAND; t++) begin
            ax = rcoord(-150, 600);
            ay = rcoord(-150, 540);
            bx = rcoord(-150, 600);
            by = rcoord(-150, 540);
            cx = rcoord(-150, 600);
            cy = rcoord(-150, 540);
            if ($urandom_range(5, 0) == 0) begin
                cx = 2 * bx - ax;
                cy = 2 * by - ay;
            end
            a = mkv(ax, ay, 1000 + 3 * t);
            b = mkv(bx, by, 1001 + 3 * t);
            c = mkv(cx, cy, 1002 + 3 * t);
            e = model(a, b, c, emit);
            if (emit) exp_q.push_back(e);
            else      exp_drops++;
            push(a); push(b); push(c);
        end
        k = 0;
        while ((k < 20000) && !((got_q.size() >= base_got + exp_q.size()) && (rd_ptr == wr_ptr)
                                && (int'(bus.o_drop_count) == exp_drops))) begin
            tick();
            bus.i_tri_ready = ($urandom_range(3, 0) != 0);
            stall           = ($urandom_range(7, 0) == 0);
            k++;
        end
        stall           = 1'b0;
        bus.i_tri_ready = 1'b1;
        chk("rand_completed_in_budget", longint'(k < 20000), 1);
        repeat (10) tick();
        chk("rand_count", got_q.size() - base_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_got + i < got_q.size())
                chk_tri($sformatf("rand%0d", i), got_q[base_got + i], exp_q[i]);
        end
        chk("rand_drop_count", longint'(bus.o_drop_count), exp_drops);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/triangle_assembler.md
Name: triangle_assembler

Overview:
Consumes vertices from the fall-through vertex FIFO, groups every three consecutive vertices into one triangle, and computes a signed doubled area and a screen-clamped bounding box. Degenerate and fully off-screen triangles are dropped. Surviving triangles are presented to the rasterizer setup stage over a valid/ready handshake.

Parameters:
VERT_W, 104, vertex width; fields {x[15:0] signed, y[15:0] signed, z[7:0], u[31:0], v[31:0]}, x at MSBs
SCREEN_W, 320, screen width in pixels; clamp limit for x is SCREEN_W-1
SCREEN_H, 240, screen height in pixels; clamp limit for y is SCREEN_H-1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_fifo_data  in  VERT_W  head-of-FIFO vertex, valid combinationally while !i_fifo_empty
i_fifo_empty  in  1  FIFO empty flag
o_fifo_re  out  1  pop strobe; vertex captured on the same edge
o_tri_valid  out  1  triangle available
i_tri_ready  in  1  downstream accepts the triangle
o_v0, o_v1, o_v2  out  VERT_W each  triangle vertices, in arrival order
o_area  out  35  signed doubled area
o_bb_min_x, o_bb_max_x  out  16 each  clamped bounding box x, unsigned
o_bb_min_y, o_bb_max_y  out  16 each  clamped bounding box y, unsigned
o_drop_count  out  16  count of dropped triangles, saturating

Behaviour:
- Reset: i_rst and i_clk as already decided (i_rst synchronous, active-high; clock i_clk).
  - Go to S_COLLECT with vertex index 0.
  - o_tri_valid=0, o_fifo_re=0, o_drop_count=0.
  - o_v*, o_area and o_bb_* = 0.
  - A reset mid-triangle discards any partially collected vertices. No pops occur while i_rst is high.
- FSM states: S_COLLECT, S_AREA, S_CHECK, S_OUT.
- S_COLLECT:
  - o_fifo_re = !i_fifo_empty, combinational; asserted only in this state.
  - On each pop edge, store i_fifo_data into slot[idx] and increment idx.
  - The pop that fills slot 2 resets idx to 0 and transitions to S_AREA.
- S_AREA (one cycle): register the following.
  - dx1=x1-x0, dy1=y1-y0, dx2=x2-x0, dy2=y2-y0, each 17-bit signed.
  - area = dx1*dy2 - dx2*dy1: 34-bit products, 35-bit signed result.
  - Raw min/max of x and y over the three vertices, kept signed.
  - Transition to S_CHECK.
- S_CHECK (one cycle):
  - Drop if area==0.
  - Drop if raw max_x<0, raw min_x>SCREEN_W-1, raw max_y<0, or raw min_y>SCREEN_H-1.
  - On drop: o_drop_count+1, saturating at 0xFFFF; transition to S_COLLECT.
  - Otherwise: clamp min/max x to [0,SCREEN_W-1] and y to [0,SCREEN_H-1], load all outputs, transition to S_OUT.
- S_OUT:
  - o_tri_valid=1; all triangle outputs held stable until i_tri_ready.
  - On valid&&ready: o_tri_valid deasserts next cycle; transition to S_COLLECT.
  - No FIFO pops in this state; backpressure propagates to the FIFO.
- Latency:
  - o_tri_valid rises after the 2nd edge following the edge that pops vertex 2.
  - Best-case throughput is 1 triangle per 6 cycles when the FIFO is never empty and ready is held high.
- An empty FIFO mid-triangle stalls S_COLLECT indefinitely; collected slots are retained.
- o_tri_valid never depends combinationally on i_tri_ready.

Optional Feature:
BACKFACE_CULL_EN
- Defined: S_CHECK additionally drops triangles with area<0 (back-facing) and counts them in o_drop_count.
- Undefined: negative-area triangles are emitted unchanged with negative o_area; the downstream stage handles winding.

Test Plan:
- Front-facing emit:
  - Stimulus: push (10,10),(20,10),(10,20), ready=1.
  - Response: one handshake; o_area=100; bbox x 10..20, y 10..20; vertices in push order; drop_count=0.
- Back-facing:
  - Stimulus: push (10,10),(10,20),(20,10).
  - Response with BACKFACE_CULL_EN: no valid, drop_count=1.
  - Response without BACKFACE_CULL_EN: emitted with o_area=-100.
- Degenerate:
  - Stimulus: collinear (0,0),(5,5),(10,10).
  - Response: area 0; no o_tri_valid; drop_count increments by 1.
- Off-screen and clamp:
  - Stimulus 1: push (-50,-50),(-40,-50),(-50,-40).
  - Response 1: dropped.
  - Stimulus 2: then push (-5,-5),(400,0),(0,300).
  - Response 2: emitted, o_area=123500, bbox x 0..319, y 0..239.
- Backpressure and stall:
  - Stimulus 1: hold i_tri_ready=0 for 5 cycles in S_OUT.
  - Response 1: outputs stable, o_fifo_re=0 throughout.
  - Stimulus 2: FIFO empty after 2 vertices for 10 cycles.
  - Response 2: the 3rd vertex, when it arrives, completes the same triangle.
- Reset mid-operation:
  - Stimulus: assert i_rst after 2 vertices are popped, then push 3 new vertices.
  - Response: the triangle uses only the new vertices; drop_count=0 after reset.
